// File: rtl/wrt_ptr_full.sv
// Write-side pointer and flag logic for an asynchronous FIFO: Gray/binary write
// pointer, full/almost-full detection, fill level and a sticky overflow flag.
module wrt_ptr_full #(
    parameter int ADDR_WIDTH = 7,
    parameter int AF_THRESH  = 120
) (
    input  logic                  wrt_clk,
    input  logic                  wrt_rst,
    input  logic                  wrt_en,
    input  logic [ADDR_WIDTH:0]   wq2_rd_ptr,
    input  logic                  wrt_ovf_clr,
    output logic [ADDR_WIDTH:0]   wrt_ptr,
    output logic [ADDR_WIDTH-1:0] wrt_addr,
    output logic                  wrt_inc,
    output logic                  wrt_full,
    output logic                  wrt_almost_full,
    output logic [ADDR_WIDTH:0]   wrt_level,
    output logic                  wrt_ovf
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_cmp;
    logic          full_next;
    logic          af_next;

    // Reset term keeps the memory strobe quiet while the pointers are held at zero.
    assign wrt_inc    = wrt_en & ~wrt_full & ~wrt_rst;
    assign wbin_next  = wbin + PW'(wrt_inc);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign wrt_addr   = wbin[ADDR_WIDTH-1:0];

    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rd_ptr >> i);
        end
    end

    // Full when write pointer is exactly one lap ahead of the synchronized read pointer.
    assign full_cmp   = {~wq2_rd_ptr[PW-1:PW-2], wq2_rd_ptr[PW-3:0]};
    assign full_next  = (wgray_next == full_cmp);
    assign level_next = wbin_next - rbin;
    assign af_next    = (level_next >= PW'(AF_THRESH));

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            wbin            <= '0;
            wrt_ptr         <= '0;
            wrt_full        <= 1'b0;
            wrt_almost_full <= 1'b0;
            wrt_level       <= '0;
        end else begin
            wbin            <= wbin_next;
            wrt_ptr         <= wgray_next;
            wrt_full        <= full_next;
            wrt_almost_full <= af_next;
            wrt_level       <= level_next;
        end
    end

    // A dropped write outranks a clear in the same cycle.
    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            wrt_ovf <= 1'b0;
        end else if (wrt_en && wrt_full) begin
            wrt_ovf <= 1'b1;
        end else if (wrt_ovf_clr) begin
            wrt_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wrt_ptr_full.sv
// Directed bench for wrt_ptr_full: fill/full, overflow, almost-full, read release,
// pointer wrap under streaming, and asynchronous reset.
module tb_wrt_ptr_full;

    logic       wrt_clk = 1'b0;
    logic       wrt_rst;
    logic       wrt_en;
    logic [7:0] wq2_rd_ptr;
    logic       wrt_ovf_clr;
    logic [7:0] wrt_ptr;
    logic [6:0] wrt_addr;
    logic       wrt_inc;
    logic       wrt_full;
    logic       wrt_almost_full;
    logic [7:0] wrt_level;
    logic       wrt_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 wrt_clk = ~wrt_clk;

    wrt_ptr_full #(.ADDR_WIDTH(7), .AF_THRESH(120)) dut (
        .wrt_clk(wrt_clk), .wrt_rst(wrt_rst), .wrt_en(wrt_en),
        .wq2_rd_ptr(wq2_rd_ptr), .wrt_ovf_clr(wrt_ovf_clr),
        .wrt_ptr(wrt_ptr), .wrt_addr(wrt_addr), .wrt_inc(wrt_inc),
        .wrt_full(wrt_full), .wrt_almost_full(wrt_almost_full),
        .wrt_level(wrt_level), .wrt_ovf(wrt_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge wrt_clk);
        #1;
    endtask

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        wrt_rst = 1'b1;
        wrt_en = 1'b0;
        wrt_ovf_clr = 1'b0;
        wq2_rd_ptr = 8'h00;
        tick();
        wrt_rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ptr"},   32'(wrt_ptr), 32'h0);
        chk({tag, "_addr"},  32'(wrt_addr), 32'h0);
        chk({tag, "_level"}, 32'(wrt_level), 32'h0);
        chk({tag, "_flags"}, {28'h0, wrt_inc, wrt_full, wrt_almost_full, wrt_ovf}, 32'h0);
    endtask

    initial begin
        int bad_addr;
        int bad_level;
        int bad_bits;
        int wrap_seen;
        logic [7:0] prev;

        wrt_rst = 1'b1;
        wrt_en = 1'b1;
        wrt_ovf_clr = 1'b0;
        wq2_rd_ptr = 8'h00;
        tick();
        tick();
        chk_all_zero("reset");

        // Fill 128 from empty; first write lands on the first edge after release.
        wrt_rst = 1'b0;
        bad_addr = 0;
        for (int k = 0; k < 128; k++) begin
            #1;
            if (wrt_addr != 7'(k) || wrt_inc != 1'b1) bad_addr++;
            tick();
        end
        wrt_en = 1'b0;
        chk("fill_addr_seq", 32'(bad_addr), 0);
        chk("fill_ptr", 32'(wrt_ptr), 32'hC0);
        chk("fill_full", 32'(wrt_full), 1);
        chk("fill_level", 32'(wrt_level), 128);
        chk("fill_af", 32'(wrt_almost_full), 1);

        // Writes while full are dropped and latch overflow.
        wrt_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ovf_inc", 32'(wrt_inc), 0);
            tick();
            chk("ovf_ptr", 32'(wrt_ptr), 32'hC0);
            chk("ovf_set", 32'(wrt_ovf), 1);
        end
        wrt_en = 1'b0;
        tick();
        chk("ovf_hold", 32'(wrt_ovf), 1);
        wrt_ovf_clr = 1'b1;
        tick();
        wrt_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(wrt_ovf), 0);
        wrt_en = 1'b1;
        wrt_ovf_clr = 1'b1;
        tick();
        wrt_en = 1'b0;
        chk("ovf_set_wins", 32'(wrt_ovf), 1);
        tick();
        wrt_ovf_clr = 1'b0;
        chk("ovf_clr2", 32'(wrt_ovf), 0);

        // Read advance releases full; next write refills.
        wq2_rd_ptr = 8'h01;
        tick();
        chk("rel_full", 32'(wrt_full), 0);
        chk("rel_level", 32'(wrt_level), 127);
        wrt_en = 1'b1;
        #1;
        chk("rel_inc", 32'(wrt_inc), 1);
        tick();
        wrt_en = 1'b0;
        chk("refull", 32'(wrt_full), 1);
        chk("refull_level", 32'(wrt_level), 128);
        chk("refull_ptr", 32'(wrt_ptr), 32'hC1);

        // Almost-full threshold at 120.
        do_reset();
        wrt_en = 1'b1;
        repeat (119) tick();
        wrt_en = 1'b0;
        chk("af_119_level", 32'(wrt_level), 119);
        chk("af_119", 32'(wrt_almost_full), 0);
        wrt_en = 1'b1;
        tick();
        wrt_en = 1'b0;
        chk("af_120", 32'(wrt_almost_full), 1);
        chk("af_120_level", 32'(wrt_level), 120);
        wq2_rd_ptr = 8'h01;
        tick();
        chk("af_rd_level", 32'(wrt_level), 119);
        chk("af_rd_clear", 32'(wrt_almost_full), 0);
        // Write and read in the same cycle: level unchanged.
        wrt_en = 1'b1;
        wq2_rd_ptr = 8'h03;
        tick();
        wrt_en = 1'b0;
        chk("wr_rd_level", 32'(wrt_level), 119);
        chk("wr_rd_ptr", 32'(wrt_ptr), 32'h45);

        // Stream 300 writes with the reader trailing; pointer wraps through 0x80->0x00.
        do_reset();
        bad_level = 0;
        bad_bits = 0;
        wrap_seen = 0;
        prev = 8'h00;
        wrt_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wq2_rd_ptr = (k >= 1) ? gray(8'(k - 1)) : 8'h00;
            tick();
            if (wrt_level != ((k >= 1) ? 8'd2 : 8'd1) || wrt_full) bad_level++;
            if ($countones(wrt_ptr ^ prev) != 1) bad_bits++;
            if (prev == 8'h80 && wrt_ptr == 8'h00) wrap_seen++;
            prev = wrt_ptr;
        end
        wrt_en = 1'b0;
        chk("stream_level", 32'(bad_level), 0);
        chk("stream_gray", 32'(bad_bits), 0);
        chk("stream_wrap", 32'(wrap_seen), 1);
        chk("stream_ptr", 32'(wrt_ptr), 32'(gray(8'(300))));

        // Asynchronous reset mid-fill, between clock edges.
        do_reset();
        wrt_en = 1'b1;
        repeat (50) tick();
        chk("mid_level", 32'(wrt_level), 50);
        #2;
        wrt_rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        wrt_rst = 1'b0;
        tick();
        wrt_en = 1'b0;
        chk("post_rst_addr", 32'(wrt_addr), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
